// File: rtl/stopwatch_pkg.sv
// Shared types, 7-segment constants and the segment decoder for the stopwatch display.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Segment order gfedcba, a low bit lights the segment.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/stopwatch_display_if.sv
// Bundle between the stopwatch counter (master) and the display stage (slave).
interface stopwatch_display_if #(
  parameter int IN_W = 32
);
  logic [IN_W-1:0] value;
  logic [6:0]      hex0;
  logic [6:0]      hex1;
  logic [6:0]      hex2;
  logic [6:0]      hex3;
  logic            dp_n;
  logic            busy;
  logic            valid;
  logic            overflow;

  modport master (
    output value,
    input  hex0, hex1, hex2, hex3, dp_n, busy, valid, overflow
  );

  modport slave (
    input  value,
    output hex0, hex1, hex2, hex3, dp_n, busy, valid, overflow
  );
endinterface

// File: rtl/stopwatch_display_bin2bcd.sv
// Sequential double-dabble core: one add-3/shift step per cycle, BIN_W steps per conversion.
module bin2bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [BIN_W-1:0]      bin_i,
  output logic                  busy_o,
  output logic                  last_o,
  output logic [DIGITS*4-1:0]   bcd_o
);
  localparam int BCD_W = DIGITS * 4;
  localparam int CNT_W = $clog2(BIN_W);

  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] adj_s;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  always_comb begin
    adj_s = bcd_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_q[d*4 +: 4] >= 4'd5) begin
        adj_s[d*4 +: 4] = bcd_q[d*4 +: 4] + 4'd3;
      end else begin
        adj_s[d*4 +: 4] = bcd_q[d*4 +: 4];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      bin_q  <= bin_i;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      bcd_q <= {adj_s[BCD_W-2:0], bin_q[BIN_W-1]};
      bin_q <= {bin_q[BIN_W-2:0], 1'b0};
      cnt_q <= cnt_q + CNT_W'(1);
      if (last_o) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign busy_o = busy_q;
  assign last_o = (cnt_q == CNT_W'(BIN_W - 1));
  assign bcd_o  = bcd_q;
endmodule

// File: rtl/stopwatch_display.sv
// Stopwatch display stage: change detect, saturation, BCD conversion and 7-segment output registers.
// Optional feature macro: DECIMAL_POINT_EN (drives dp_n low once the first conversion completes).
module stopwatch_display #(
  parameter int IN_W    = 32,
  parameter int BIN_W   = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic              clk,
  input  logic              rst,
  stopwatch_display_if.slave sw
);
  import stopwatch_pkg::*;

  localparam int DIGITS = 4;

  state_e              state_q;
  logic [IN_W-1:0]     last_val_q;
  logic                ovf_pend_q;
  logic [6:0]          hex0_q, hex1_q, hex2_q, hex3_q;
  logic                dp_q, busy_q, valid_q, ovf_q;

  logic                start_s;
  logic                ovf_s;
  logic [BIN_W-1:0]    sat_s;
  logic                core_busy_s;
  logic                core_last_s;
  logic [DIGITS*4-1:0] bcd_s;

  // Saturate on the full-width value before narrowing to the converter width.
  assign ovf_s   = (sw.value > IN_W'(MAX_VAL));
  assign sat_s   = ovf_s ? BIN_W'(MAX_VAL) : sw.value[BIN_W-1:0];
  assign start_s = (state_q == IDLE) && (!valid_q || (sw.value != last_val_q));

  bin2bcd_seq #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_s),
    .bin_i   (sat_s),
    .busy_o  (core_busy_s),
    .last_o  (core_last_s),
    .bcd_o   (bcd_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_val_q <= '0;
      ovf_pend_q <= 1'b0;
      hex0_q     <= SEG_BLANK;
      hex1_q     <= SEG_BLANK;
      hex2_q     <= SEG_BLANK;
      hex3_q     <= SEG_BLANK;
      dp_q       <= 1'b1;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_s) begin
            last_val_q <= sw.value;
            ovf_pend_q <= ovf_s;
            busy_q     <= 1'b1;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          if (core_busy_s && core_last_s) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          hex0_q  <= seg_decode(bcd_s[3:0]);
          hex1_q  <= seg_decode(bcd_s[7:4]);
          hex2_q  <= seg_decode(bcd_s[11:8]);
          hex3_q  <= seg_decode(bcd_s[15:12]);
          valid_q <= 1'b1;
          ovf_q   <= ovf_pend_q;
          busy_q  <= 1'b0;
`ifdef DECIMAL_POINT_EN
          dp_q    <= 1'b0;
`else
          dp_q    <= 1'b1;
`endif
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sw.hex0     = hex0_q;
  assign sw.hex1     = hex1_q;
  assign sw.hex2     = hex2_q;
  assign sw.hex3     = hex3_q;
  assign sw.dp_n     = dp_q;
  assign sw.busy     = busy_q;
  assign sw.valid    = valid_q;
  assign sw.overflow = ovf_q;
endmodule

// File: tb/tb_stopwatch_display.sv
// Self-checking bench for stopwatch_display against a decimal-arithmetic reference model.
module tb_stopwatch_display;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  stopwatch_display_if #(.IN_W(32)) sw ();

  stopwatch_display dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw)
  );

  int checks   = 0;
  int failures = 0;

  logic [27:0] BLANK4 = 28'hFFFFFFF;

  // Reference model state: what the display should currently show.
  logic [31:0] last_v;
  logic        have_valid;
  logic [27:0] cur_disp;
  logic        cur_ovf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] t [10];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
          7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return t[d];
  endfunction

  function automatic logic [27:0] disp_of(input logic [31:0] v);
    int s;
    s = (v > 32'd9999) ? 9999 : int'(v);
    return {seg_of((s / 1000) % 10), seg_of((s / 100) % 10), seg_of((s / 10) % 10), seg_of(s % 10)};
  endfunction

  function automatic logic [27:0] disp_now();
    return {sw.hex3, sw.hex2, sw.hex1, sw.hex0};
  endfunction

  function automatic logic exp_dp(input logic vld);
`ifdef DECIMAL_POINT_EN
    return ~vld;
`else
    return (vld == 1'b0) ? 1'b1 : 1'b1;
`endif
  endfunction

  // Drive v on a falling edge and follow the conversion for 20 cycles.
  task automatic run_conv(input logic [31:0] v);
    logic        conv;
    logic [27:0] new_disp;
    int          busy_cnt;
    conv     = !have_valid || (v != last_v);
    new_disp = conv ? disp_of(v) : cur_disp;
    busy_cnt = 0;
    sw.value = v;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (sw.busy === 1'b1) busy_cnt++;
      if (i == 15 && conv && new_disp != cur_disp)
        check_eq("hold_before_latency", {4'h0, disp_now()}, {4'h0, cur_disp});
      if (i == 16) begin
        check_eq("digits", {4'h0, disp_now()}, {4'h0, new_disp});
        check_eq("valid", {31'h0, sw.valid}, 32'd1);
        check_eq("overflow", {31'h0, sw.overflow}, {31'h0, conv ? (v > 32'd9999) : cur_ovf});
        check_eq("dp_n", {31'h0, sw.dp_n}, {31'h0, exp_dp(1'b1)});
      end
    end
    check_eq("busy_cycles", busy_cnt, conv ? 32'd15 : 32'd0);
    if (conv) begin
      last_v  = v;
      cur_ovf = (v > 32'd9999);
    end
    have_valid = 1'b1;
    cur_disp   = new_disp;
  endtask

  task automatic check_blank(input string tag);
    check_eq({tag, "_hex"}, {4'h0, disp_now()}, {4'h0, BLANK4});
    check_eq({tag, "_valid"}, {31'h0, sw.valid}, 32'd0);
    check_eq({tag, "_busy"}, {31'h0, sw.busy}, 32'd0);
    check_eq({tag, "_ovf"}, {31'h0, sw.overflow}, 32'd0);
    check_eq({tag, "_dp"}, {31'h0, sw.dp_n}, 32'd1);
  endtask

  initial begin
    logic [27:0] prev;
    logic [31:0] rv;
    int          bad;

    sw.value   = 32'd0;
    have_valid = 1'b0;
    last_v     = 32'd0;
    cur_disp   = BLANK4;
    cur_ovf    = 1'b0;

    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    check_blank("reset");
    rst = 1'b0;
    run_conv(32'd0);

    run_conv(32'd1234);
    check_eq("digits_1234", {4'h0, disp_now()}, {4'h0, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});
    run_conv(32'd10000);
    check_eq("sat_9999", {4'h0, disp_now()}, {4'h0, {4{7'b0010000}}});
    run_conv(32'd42);
    run_conv(32'd42);

    // Change mid-SHIFT: only the old, 0005 or 0007 displays may ever appear.
    prev     = cur_disp;
    bad      = 0;
    sw.value = 32'd5;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 3) sw.value = 32'd7;
      if (disp_now() != prev && disp_now() != disp_of(32'd5) && disp_now() != disp_of(32'd7)) bad++;
      if (i == 16) check_eq("mid_first", {4'h0, disp_now()}, {4'h0, disp_of(32'd5)});
      if (i == 32) check_eq("mid_second", {4'h0, disp_now()}, {4'h0, disp_of(32'd7)});
    end
    check_eq("mid_no_glitch", bad, 32'd0);
    last_v   = 32'd7;
    cur_disp = disp_of(32'd7);

    // Reset pulse during the conversion of 8888.
    sw.value = 32'd8888;
    repeat (9) @(negedge clk);
    check_eq("abort_busy_pre", {31'h0, sw.busy}, 32'd1);
    #2 rst = 1'b1;
    #1 check_blank("abort");
    @(negedge clk);
    rst        = 1'b0;
    have_valid = 1'b0;
    cur_disp   = BLANK4;
    cur_ovf    = 1'b0;
    run_conv(32'd8888);

    // Randomised values including boundaries and repeats.
    for (int k = 0; k < 25; k++) begin
      case ($urandom_range(0, 3))
        0: rv = $urandom_range(0, 9999);
        1: rv = $urandom;
        2: rv = ($urandom_range(0, 1) == 0) ? 32'd9999 : 32'd10000;
        default: rv = last_v;
      endcase
      run_conv(rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
